// File: rtl/handler_arb_pkg.sv
// Shared types and constants for the handler port arbiter.
package handler_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } harb_state_e;

    localparam int HARB_NUM_CH_DEF = 4;

    // Packed metadata layout, LSB first: id, rows, cols, name
    localparam int META_ID_LSB   = 0;
    localparam int META_ID_W     = 8;
    localparam int META_ROWS_LSB = META_ID_LSB + META_ID_W;
    localparam int META_ROWS_W   = 16;
    localparam int META_COLS_LSB = META_ROWS_LSB + META_ROWS_W;
    localparam int META_COLS_W   = 16;
    localparam int META_NAME_LSB = META_COLS_LSB + META_COLS_W;
    localparam int META_NAME_W   = 48;
    localparam int HARB_META_W   = META_NAME_LSB + META_NAME_W;

endpackage

// File: rtl/handler_arb_watchdog.sv
// Idle-run watchdog: counts enabled cycles, restarts on clear, flags expiry at the limit.
module handler_arb_watchdog #(
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= cnt_q + CW'(1);
    end

    // Fires on the last allowed cycle so the FSM leaves RUN at exactly the limit
    assign expire = enable && !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/handler_port_arbiter.sv
// Routes one handler channel (picked by a one-hot start) to storage and input buffer.
// Optional RUN watchdog with sticky timeout: define HANDLER_ARB_WATCHDOG_EN.
module handler_port_arbiter
    import handler_arb_pkg::*;
#(
    parameter int  NUM_CH         = HARB_NUM_CH_DEF,
    parameter int  DATA_WIDTH     = 32,
    parameter int  META_WIDTH     = HARB_META_W,
    parameter int  ADDR_WIDTH     = 14,
    parameter int  BUF_ADDR_WIDTH = 11,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int CH_W           = $clog2(NUM_CH)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_CH-1:0]                        mode_sel,
    input  logic                                     start,
    output logic [NUM_CH-1:0]                        ch_start,
    input  logic [NUM_CH-1:0]                        ch_busy,
    input  logic [NUM_CH-1:0]                        ch_done,
    input  logic [NUM_CH-1:0]                        ch_error,
    input  logic [NUM_CH-1:0]                        ch_write_request,
    input  logic [NUM_CH-1:0]                        ch_data_valid,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]        ch_data,
    input  logic [NUM_CH-1:0][META_WIDTH-1:0]        ch_meta,
    input  logic [NUM_CH-1:0][BUF_ADDR_WIDTH-1:0]    ch_buf_rd_addr,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]        ch_storage_rd_addr,
    output logic                                     write_request,
    output logic [DATA_WIDTH-1:0]                    data_in,
    output logic                                     data_valid,
    output logic [META_WIDTH-1:0]                    meta,
    output logic [BUF_ADDR_WIDTH-1:0]                buf_rd_addr,
    output logic [ADDR_WIDTH-1:0]                    storage_rd_addr,
    output logic                                     buf_clear,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     error,
    output logic [CH_W-1:0]                          active_ch,
    output logic                                     timeout
);

    harb_state_e       state_q, state_d;
    logic [CH_W-1:0]   active_q, sel_idx;
    logic [NUM_CH-1:0] run_mode_q, mode_q, mode_prev_q;
    logic [1:0]        vld_pipe;
    logic              in_idle, in_run, sel_onehot, abort, wd_expire;
    logic              start_ok, err_c, done_c;
    logic              unused_busy;

    assign in_idle    = (state_q == ST_IDLE);
    assign in_run     = (state_q == ST_RUN);
    assign sel_onehot = $onehot(mode_sel);

    // Handler busy is implied by RUN, so the per-channel flags carry no extra information
    assign unused_busy = ^ch_busy;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (mode_sel[i]) sel_idx = CH_W'(i);
    end

    assign abort = ch_error[active_q] || (mode_sel != run_mode_q) || wd_expire;

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        err_c    = 1'b0;
        done_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sel_onehot) begin
                        state_d  = ST_RUN;
                        start_ok = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                    err_c   = 1'b1;
                end else if (ch_done[active_q]) begin
                    state_d = ST_CLEAR;
                    done_c  = 1'b1;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // vld_pipe keeps the idle mode-change detector quiet until two real samples exist
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            run_mode_q  <= '0;
            ch_start    <= '0;
            mode_q      <= '0;
            mode_prev_q <= '0;
            vld_pipe    <= '0;
        end else begin
            state_q     <= state_d;
            ch_start    <= start_ok ? mode_sel : '0;
            if (start_ok) begin
                active_q   <= sel_idx;
                run_mode_q <= mode_sel;
            end
            mode_q      <= mode_sel;
            mode_prev_q <= mode_q;
            vld_pipe    <= {vld_pipe[0], 1'b1};
        end
    end

    // IDLE decodes of live inputs are masked while reset is held
    assign error     = err_c && rst_n;
    assign done      = done_c;
    assign busy      = !in_idle;
    assign active_ch = active_q;
    assign buf_clear = (state_q == ST_CLEAR) ||
                       (in_idle && vld_pipe[1] && (mode_q != mode_prev_q));

    assign write_request   = in_run && ch_write_request[active_q];
    assign data_valid      = in_run && ch_data_valid[active_q];
    assign data_in         = in_run ? ch_data[active_q] : '0;
    assign meta            = in_run ? ch_meta[active_q] : '0;
    assign storage_rd_addr = in_run ? ch_storage_rd_addr[active_q] : '0;

    always_comb begin
        buf_rd_addr = '0;
        if (in_run)
            buf_rd_addr = ch_buf_rd_addr[active_q];
        else if (in_idle && sel_onehot && rst_n)
            buf_rd_addr = ch_buf_rd_addr[sel_idx];
    end

`ifdef HANDLER_ARB_WATCHDOG_EN
    logic wd_clear, timeout_q;

    assign wd_clear = !in_run || ch_data_valid[active_q];

    handler_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (in_run),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout_q <= 1'b0;
        else if (start_ok)
            timeout_q <= 1'b0;
        else if (in_run && wd_expire)
            timeout_q <= 1'b1;
    end

    assign timeout = timeout_q;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYCLES);
    assign wd_expire  = 1'b0;
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_handler_port_arbiter.sv
// Directed table-driven bench for handler_port_arbiter plus hand sequences for reset and watchdog.
module tb_handler_port_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int MW  = 88;
    localparam int AW  = 14;
    localparam int BW  = 11;
    localparam int NV  = 29;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NCH-1:0]          mode_sel, ch_start, ch_busy, ch_done, ch_error;
    logic [NCH-1:0]          ch_write_request, ch_data_valid;
    logic                    start;
    logic [NCH-1:0][DW-1:0]  ch_data;
    logic [NCH-1:0][MW-1:0]  ch_meta;
    logic [NCH-1:0][BW-1:0]  ch_buf_rd_addr;
    logic [NCH-1:0][AW-1:0]  ch_storage_rd_addr;
    logic                    write_request, data_valid, buf_clear, busy, done, error, timeout;
    logic [DW-1:0]           data_in;
    logic [MW-1:0]           meta;
    logic [BW-1:0]           buf_rd_addr;
    logic [AW-1:0]           storage_rd_addr;
    logic [1:0]              active_ch;

    always #5 clk = ~clk;

    handler_port_arbiter #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .META_WIDTH(MW), .ADDR_WIDTH(AW),
        .BUF_ADDR_WIDTH(BW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .start(start), .ch_start(ch_start),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_error(ch_error),
        .ch_write_request(ch_write_request), .ch_data_valid(ch_data_valid),
        .ch_data(ch_data), .ch_meta(ch_meta), .ch_buf_rd_addr(ch_buf_rd_addr),
        .ch_storage_rd_addr(ch_storage_rd_addr), .write_request(write_request),
        .data_in(data_in), .data_valid(data_valid), .meta(meta), .buf_rd_addr(buf_rd_addr),
        .storage_rd_addr(storage_rd_addr), .buf_clear(buf_clear), .busy(busy), .done(done),
        .error(error), .active_ch(active_ch), .timeout(timeout)
    );

    typedef struct {
        logic [3:0]  m;
        logic        s;
        logic [3:0]  dn, er, dv;
        logic [3:0]  cs;
        logic        err, dne, bsy, bclr;
        logic [1:0]  act;
        logic        dvo;
        logic [31:0] din;
        logic [10:0] bra;
    } vec_t;

    vec_t tbl [NV];
    int   n_tot = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          m     s     dn    er    dv    | cs    err   done  busy  bclr  act   dvo   din           bra
        tbl[0]  = '{4'h2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,        11'h11};
        tbl[1]  = '{4'h2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        11'h11};
        tbl[2]  = '{4'h2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,        11'h11};
        tbl[3]  = '{4'h2, 1'b0, 4'h0, 4'h0, 4'h2, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'hA0000001, 11'h11};
        tbl[4]  = '{4'h2, 1'b1, 4'h0, 4'h0, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'hA0000001, 11'h11};
        tbl[5]  = '{4'h2, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'hA0000001, 11'h11};
        tbl[6]  = '{4'h2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,        11'h00};
        tbl[7]  = '{4'h2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        11'h11};
        tbl[8]  = '{4'h6, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        11'h00};
        tbl[9]  = '{4'h6, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,        11'h00};
        tbl[10] = '{4'h4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        11'h12};
        tbl[11] = '{4'h4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,        11'h12};
        tbl[12] = '{4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        11'h12};
        tbl[13] = '{4'h4, 1'b0, 4'h0, 4'h0, 4'h1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 11'h12};
        tbl[14] = '{4'h4, 1'b0, 4'h1, 4'h1, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'hDEADBEEF, 11'h12};
        tbl[15] = '{4'h4, 1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 11'h12};
        tbl[16] = '{4'h4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        11'h00};
        tbl[17] = '{4'h8, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0,        11'h13};
        tbl[18] = '{4'h8, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0,        11'h13};
        tbl[19] = '{4'h8, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0,        11'h13};
        tbl[20] = '{4'h8, 1'b0, 4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'hA0000003, 11'h13};
        tbl[21] = '{4'h8, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0,        11'h00};
        tbl[22] = '{4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        11'h10};
        tbl[23] = '{4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0,        11'h10};
        tbl[24] = '{4'h1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        11'h10};
        tbl[25] = '{4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'hA0000000, 11'h10};
        tbl[26] = '{4'h4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'hA0000000, 11'h10};
        tbl[27] = '{4'h4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        11'h00};
        tbl[28] = '{4'h4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,        11'h12};

        for (int i = 0; i < NCH; i++) begin
            ch_data[i]            = 32'hA0000000 + 32'(i);
            ch_meta[i]            = {8'(i), 80'h00C0FFEE};
            ch_buf_rd_addr[i]     = 11'h10 + 11'(i);
            ch_storage_rd_addr[i] = 14'h100 + 14'(i);
        end
        ch_data[2]       = 32'hDEADBEEF;
        ch_busy          = '0;
        ch_done          = '0;
        ch_error         = '0;
        ch_write_request = '0;
        ch_data_valid    = '0;

        // Reset: outputs quiet even with a bad start and a one-hot select on the inputs
        rst_n    = 1'b0;
        mode_sel = 4'b0110;
        start    = 1'b1;
        #3;
        chk("rst.error", error, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.ch_start", ch_start, 4'h0);
        chk("rst.buf_clear", buf_clear, 1'b0);
        chk("rst.active_ch", active_ch, 2'd0);
        chk("rst.timeout", timeout, 1'b0);
        mode_sel = 4'b0010;
        start    = 1'b0;
        #1;
        chk("rst.buf_rd_addr", buf_rd_addr, 11'h0);
        chk("rst.meta", meta, 88'h0);
        chk("rst.data_valid", data_valid, 1'b0);
        mode_sel = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < NV; i++) begin
            mode_sel      = tbl[i].m;
            start         = tbl[i].s;
            ch_done       = tbl[i].dn;
            ch_error      = tbl[i].er;
            ch_data_valid = tbl[i].dv;
            #2;
            chk($sformatf("v%0d.ch_start", i), ch_start, tbl[i].cs);
            chk($sformatf("v%0d.error", i), error, tbl[i].err);
            chk($sformatf("v%0d.done", i), done, tbl[i].dne);
            chk($sformatf("v%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d.buf_clear", i), buf_clear, tbl[i].bclr);
            chk($sformatf("v%0d.active_ch", i), active_ch, tbl[i].act);
            chk($sformatf("v%0d.data_valid", i), data_valid, tbl[i].dvo);
            chk($sformatf("v%0d.data_in", i), data_in, tbl[i].din);
            chk($sformatf("v%0d.buf_rd_addr", i), buf_rd_addr, tbl[i].bra);
            chk($sformatf("v%0d.timeout", i), timeout, 1'b0);
            @(posedge clk);
            #1;
        end
        start         = 1'b0;
        ch_done       = '0;
        ch_error      = '0;
        ch_data_valid = '0;

        // Storage-side routing on channel 1, then quiet outputs back in IDLE
        mode_sel = 4'b0010;
        repeat (3) step();
        start = 1'b1;
        step();
        start            = 1'b0;
        ch_write_request = 4'b0010;
        #1;
        chk("route.write_request", write_request, 1'b1);
        chk("route.meta", meta, {8'h01, 80'h00C0FFEE});
        chk("route.storage_rd_addr", storage_rd_addr, 14'h101);
        ch_write_request = 4'b1101;
        #1;
        chk("route.write_request_other", write_request, 1'b0);
        ch_done = 4'b0010;
        #1;
        chk("route.done", done, 1'b1);
        step();
        ch_done = '0;
        step();
        ch_write_request = 4'hF;
        ch_data_valid    = 4'hF;
        #1;
        chk("idle.write_request", write_request, 1'b0);
        chk("idle.data_valid", data_valid, 1'b0);
        chk("idle.meta", meta, 88'h0);
        chk("idle.storage_rd_addr", storage_rd_addr, 14'h0);
        chk("idle.data_in", data_in, 32'h0);
        ch_write_request = '0;
        ch_data_valid    = '0;

        // Reset while running: no clear pulse once released
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("midrun.busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrun.rst_busy", busy, 1'b0);
        chk("midrun.rst_ch_start", ch_start, 4'h0);
        chk("midrun.rst_active_ch", active_ch, 2'd0);
        chk("midrun.rst_buf_rd_addr", buf_rd_addr, 11'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("release%0d.buf_clear", k), buf_clear, 1'b0);
            chk($sformatf("release%0d.busy", k), busy, 1'b0);
            step();
        end

`ifdef HANDLER_ARB_WATCHDOG_EN
        // Watchdog: 16 RUN cycles without data_valid on the active channel
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 16; k++) begin
            #1;
            chk($sformatf("wd%0d.error", k), error, 1'b0);
            step();
        end
        #1;
        chk("wd16.error", error, 1'b1);
        chk("wd16.timeout", timeout, 1'b0);
        step();
        chk("wd.clear_timeout", timeout, 1'b1);
        chk("wd.clear_buf_clear", buf_clear, 1'b1);
        step();
        chk("wd.idle_timeout", timeout, 1'b1);
        start = 1'b1;
        #1;
        chk("wd.start_cycle_timeout", timeout, 1'b1);
        step();
        start = 1'b0;
        #1;
        chk("wd.restart_timeout", timeout, 1'b0);
        chk("wd.restart_busy", busy, 1'b1);
        ch_done = 4'b0010;
        step();
        ch_done = '0;
        repeat (2) step();
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/handler_port_arbiter.md
HANDLER_PORT_ARBITER -- requirements
Module: handler_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of handler channels (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: write data width.
REQ-003 SHALL have parameter META_WIDTH, default 88: packed id/rows/cols/name metadata width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 14: storage read address width.
REQ-005 SHALL have parameter BUF_ADDR_WIDTH, default 11: input buffer read address width.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000000: watchdog limit.
REQ-007 SHALL have ports clk input 1 (clock) and rst_n input 1 (reset, asynchronous, active-low).
REQ-008 SHALL have mode_sel input NUM_CH: one-hot channel select; start input 1: start pulse.
REQ-009 SHALL have ch_start output NUM_CH: per-channel start pulse.
REQ-010 SHALL have ch_busy, ch_done, ch_error inputs NUM_CH each: per-channel handler status.
REQ-011 SHALL have ch_write_request, ch_data_valid inputs NUM_CH, and ch_data input NUM_CH x DATA_WIDTH.
REQ-012 SHALL have ch_meta input NUM_CH x META_WIDTH, ch_buf_rd_addr input NUM_CH x BUF_ADDR_WIDTH, and ch_storage_rd_addr input NUM_CH x ADDR_WIDTH.
REQ-013 SHALL have write_request output 1, data_in output DATA_WIDTH, data_valid output 1, and meta output META_WIDTH, all to storage.
REQ-014 SHALL have buf_rd_addr output BUF_ADDR_WIDTH, storage_rd_addr output ADDR_WIDTH, and buf_clear output 1 (input buffer clear).
REQ-015 SHALL have busy, done, error outputs 1; active_ch output $clog2(NUM_CH); and timeout output 1.

Function
REQ-016 SHALL implement FSM IDLE, RUN, CLEAR.
- IDLE -> RUN on start with mode_sel exactly one-hot: latch active_ch and pulse ch_start[active_ch] for exactly one cycle, in the cycle after start.
REQ-017 SHALL, on start in IDLE with mode_sel zero or multi-hot, stay in IDLE, issue no ch_start, and pulse error for one cycle.
REQ-018 SHALL, in RUN, route write_request, data_in, data_valid, meta, buf_rd_addr and storage_rd_addr from latched active_ch only; live mode_sel SHALL not affect routing.
REQ-019 SHALL drive write_request, data_valid and meta to 0 in IDLE and CLEAR.
REQ-020 SHALL, in IDLE, drive buf_rd_addr from the channel selected by one-hot mode_sel, else 0.
REQ-021 SHALL, in RUN:
- on ch_done[active_ch], go to CLEAR and pulse done for one cycle;
- on ch_error[active_ch], go to CLEAR and pulse error for one cycle.
- If both are asserted in the same cycle, error SHALL win.
REQ-022 SHALL, in RUN, on any mode_sel change, go to CLEAR and pulse error (abort).
REQ-023 SHALL hold CLEAR exactly one cycle with buf_clear=1, then return to IDLE.
REQ-024 SHALL also pulse buf_clear for one cycle in IDLE whenever registered mode_sel differs from its previous value.
REQ-025 SHALL drive busy=1 in RUN and CLEAR, and busy=ch_busy[active_ch] OR-free of other channels; busy SHALL be 0 in IDLE.
REQ-026 SHALL ignore start while not in IDLE.
REQ-027 SHALL ignore status inputs from channels other than active_ch.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force IDLE and drive every output to 0, including active_ch, timeout, buf_clear and ch_start.
REQ-029 SHALL, on reset mid-RUN, issue no buf_clear on release; the first cycle after release SHALL record mode_sel without generating a mode-change clear.

Configuration
REQ-030 SHALL, with HANDLER_ARB_WATCHDOG_EN defined, count cycles in RUN, reset the count on any ch_data_valid[active_ch], and at TIMEOUT_CYCLES go to CLEAR, pulse error and set timeout sticky until the next accepted start.
REQ-031 SHALL, without HANDLER_ARB_WATCHDOG_EN, contain no counter logic and tie timeout to 0.

Structure
REQ-032 SHALL place the FSM state enum, the default NUM_CH and the meta field offsets in package handler_arb_pkg.
REQ-033 SHALL implement the watchdog as sub-module handler_arb_watchdog (clear, enable, expire), instantiated only under the macro.

Verification
REQ-034 SHALL cover: mode_sel=0010, start -> ch_start=0010 next cycle; ch_done[1] -> done pulse, then buf_clear pulse one cycle later, then IDLE.
REQ-035 SHALL cover: mode_sel=0110, start -> error pulse, ch_start=0, FSM stays IDLE.
REQ-036 SHALL cover: RUN on ch 2 with ch_data=0xDEADBEEF and ch 0 data_valid high -> data_in=0xDEADBEEF, data_valid follows ch 2 only.
REQ-037 SHALL cover: ch_done[3] and ch_error[3] in the same cycle -> error=1, done=0, then buf_clear.
REQ-038 SHALL cover: mode_sel change 0001->0100 mid-RUN -> error pulse, buf_clear, IDLE.
REQ-039 SHALL cover, with the macro and TIMEOUT_CYCLES=16: no data_valid for 16 cycles -> timeout=1, error pulse; next valid start clears timeout.
